uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive stage that sits directly downstream of the baud-rate tick generator. It consumes the generator's 16x-oversampled single-cycle sample tick and deserialises the asynchronous rx line into parallel words, LSB first. Each received word, with its framing-error flag, is held in a one-entry output buffer behind a valid/ready handshake. It flags overrun when a new frame completes while the buffer is still full.

Parameters:
DBIT, 8, number of data bits per frame (5..9)
SB_TICK, 16, stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5, 32 = 2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
rx  input  1  raw serial line, idle high, asynchronous to clk
s_tick  input  1  single-cycle sample pulse at 16x baud, from the tick generator
dout  output  DBIT  buffered received word
frame_err  output  1  framing error for the word on dout (stop bit sampled low)
rx_valid  output  1  dout/frame_err hold an unconsumed word
rx_ready  input  1  consumer accepts the word when rx_valid && rx_ready at a clk edge
overrun  output  1  one-cycle pulse when a completed frame is dropped because the buffer is full

Behaviour:
- Clock is clk. Reset is reset: asynchronous, active-low.
- Reset values: dout=0, frame_err=0, rx_valid=0, overrun=0, FSM=IDLE, counters=0, synchroniser flops=1 (line idle).
- rx passes through a 2-flop synchroniser to give rx_s. All sampling uses rx_s, which adds 2 clk of latency.
- Counters: s_cnt is 4 bits wide, or wide enough for SB_TICK-1 in STOP. n counts data bits and is ceil(log2(DBIT)) bits wide. The shift register is DBIT wide.
- FSM advances its counters only in cycles where s_tick=1. Outside those cycles all state holds, except the IDLE start detect.
- IDLE: when rx_s=0, go to START with s_cnt=0. No s_tick is needed.
- START: on s_tick with s_cnt==7 (mid start bit):
  - if rx_s=0, go to DATA with s_cnt=0 and n=0;
  - if rx_s=1, treat it as a glitch and return to IDLE. No output change.
  - Otherwise, on s_tick, s_cnt++.
- DATA: on s_tick with s_cnt==15:
  - shift rx_s into the MSB, shifting right, so the first received bit ends at bit 0;
  - set s_cnt=0;
  - if n==DBIT-1, go to STOP; otherwise n++.
- STOP: on s_tick with s_cnt==SB_TICK-1, sample rx_s and complete the frame (see below). Then:
  - go to IDLE if rx_s=1;
  - go to BRK if rx_s=0.
- BRK (break or line held low): wait until rx_s=1, then go to IDLE. No new frame starts until the line returns high.
- Frame completion, on the clk edge of the final STOP tick:
  - if the buffer is empty, or rx_valid && rx_ready in that same cycle: load dout and frame_err (=~rx_s) and set rx_valid=1 on the next clk;
  - otherwise: drop the new frame, keep the old contents, and pulse overrun=1 for exactly one clk.
- Handshake:
  - rx_valid clears on the clk after rx_valid && rx_ready, unless a frame completes in that same cycle, in which case it stays 1 with the new data.
  - dout and frame_err are stable while rx_valid=1 and not yet accepted.
- Reset mid-frame aborts the frame immediately, with no valid or overrun output. Operation resumes from IDLE on the next falling edge after reset is released.
- s_tick asserted in consecutive cycles is legal; each cycle counts as one tick.

Decomposition:
- Package uart_pkg:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, BRK};
  - constants OVERSAMPLE=16 and START_MID=7.
- One sub-module, sync_2ff: a generic 2-flop synchroniser with a parameterised reset value (here 1). It is reused by the future tx/cts path.

Test Plan:
- Setup for all scenarios: tick generator DVSR=3 (s_tick every 4 clk), 1 bit = 64 clk, DBIT=8, SB_TICK=16.
- Frame 0x55 with a good stop bit -> dout=0x55, frame_err=0. rx_valid rises 1 clk after the final STOP s_tick and about 9.5 bit times (~610 clk) after the start edge.
- rx pulse low for 3 ticks (12 clk), then high -> FSM returns to IDLE from START, rx_valid stays 0, no overrun.
- Frame 0xA3 with the stop bit held low for 3 bit times -> dout=0xA3, frame_err=1. FSM sits in BRK until rx rises, then a following 0x0F frame is received correctly.
- Frames 0x12 then 0x34 back-to-back with rx_ready=0 -> dout stays 0x12 and overrun pulses 1 clk at the end of frame 2. Then rx_ready=1 for 1 clk -> rx_valid clears.
- rx_ready=1 exactly in the completion cycle of frame 0x34 while holding 0x12 -> 0x12 is consumed, 0x34 is loaded, rx_valid stays 1, no overrun.
- reset pulled low mid-DATA of 0xC6 -> all outputs 0 immediately. After release, frame 0x81 is received as 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int START_MID  = 7;

endpackage

// File: rtl/uart_rx_if.sv
// Output side of the UART receiver: one-entry word buffer behind valid/ready.
interface uart_rx_if #(
  parameter int DBIT = 8
);
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            rx_valid;
  logic            rx_ready;
  logic            overrun;

  modport master (
    output dout,
    output frame_err,
    output rx_valid,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  dout,
    input  frame_err,
    input  rx_valid,
    input  overrun,
    output rx_ready
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with selectable reset value.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: non-blocking assignments keep the two stages as distinct flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled deserialiser with a one-entry output buffer.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     rx,
  input  logic     s_tick,
  uart_rx_if.master bus
);

  localparam int SCW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW  = $clog2(DBIT);

  localparam logic [SCW-1:0] MID_CNT  = SCW'(START_MID);
  localparam logic [SCW-1:0] BIT_END  = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] STOP_END = SCW'(SB_TICK - 1);
  localparam logic [NW-1:0]  LAST_BIT = NW'(DBIT - 1);

  logic            rx_s;
  rx_state_t       state_q, state_d;
  logic [SCW-1:0]  s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            frame_done;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_q     <= n_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d    = state_q;
    s_cnt_d    = s_cnt_q;
    n_d        = n_q;
    shreg_d    = shreg_q;
    frame_done = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_CNT) begin
            // A start bit that is high again at its midpoint was only a glitch.
            state_d = rx_s ? IDLE : DATA;
            s_cnt_d = '0;
            n_d     = '0;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == BIT_END) begin
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_q == LAST_BIT) state_d = STOP;
            else                 n_d     = n_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == STOP_END) begin
            frame_done = 1'b1;
            s_cnt_d    = '0;
            state_d    = rx_s ? IDLE : BRK;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A frame may replace the buffered word only if it is empty or being consumed now.
  always_comb begin
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;

    if (valid_q && bus.rx_ready) valid_d = 1'b0;

    if (frame_done) begin
      if (!valid_q || bus.rx_ready) begin
        dout_d  = shreg_q;
        ferr_d  = ~rx_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign bus.dout      = dout_q;
  assign bus.frame_err = ferr_q;
  assign bus.rx_valid  = valid_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: 4-clk sample tick, 64-clk bit time, DBIT=8, SB_TICK=16.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic s_tick;
  logic [1:0] tick_cnt = '0;
  int   cyc = 0;

  uart_rx_if #(.DBIT(8)) bus ();

  uart_rx #(
    .DBIT    (8),
    .SB_TICK (16)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .s_tick (s_tick),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tick_cnt <= tick_cnt + 2'd1;
    cyc      <= cyc + 1;
  end
  assign s_tick = (tick_cnt == 2'd3);

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard: {frame_err, data} pushed when a frame is sent, popped on handshake.
  logic [8:0] exp_q[$];
  int  ovr_cnt     = 0;
  int  ovr_long    = 0;
  int  valid_rises = 0;
  int  rise_cyc    = 0;
  int  last_start  = 0;
  logic ovr_prev   = 1'b0;
  logic valid_prev = 1'b0;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      if (bus.overrun) begin
        ovr_cnt++;
        if (ovr_prev) ovr_long++;
      end
      ovr_prev = bus.overrun;
      if (bus.rx_valid && !valid_prev) begin
        rise_cyc = cyc;
        valid_rises++;
      end
      valid_prev = bus.rx_valid;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {23'd0, bus.frame_err, bus.dout}, 32'hDEAD);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("data", 32'(bus.dout), 32'(e[7:0]));
          check("frame_err", 32'(bus.frame_err), 32'(e[8]));
        end
      end
    end else begin
      ovr_prev   = 1'b0;
      valid_prev = 1'b0;
    end
  end

  // Start bits are aligned to one tick phase so frame timing is repeatable.
  task automatic send_frame(input logic [7:0] d, input int stop_low_clks);
    @(negedge clk);
    while (tick_cnt != 2'd1) @(negedge clk);
    rx = 1'b0;
    last_start = cyc;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_low_clks > 0) begin
      rx = 1'b0;
      repeat (stop_low_clks) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) @(negedge clk);
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int ovr_base;
    int rises_base;

    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int ovr_base;
    int rises_base;

    bus.rx_ready = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Good frame 0x55, latency measured from the start edge.
    exp_q.push_back({1'b0, 8'h55});
    send_frame(8'h55, 0);
    lat = rise_cyc - last_start;
    check("latency_in_window", 32'(lat >= 596 && lat <= 624), 32'd1);
    bus.rx_ready = 1'b1;
    wait_drain("drain_55");

    // Short low glitch is rejected at mid start bit.
    ovr_base   = ovr_cnt;
    rises_base = valid_rises;
    @(negedge clk);
    while (tick_cnt != 2'd1) @(negedge clk);
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    check("glitch_no_valid", 32'(valid_rises - rises_base), 32'd0);
    check("glitch_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

    // Stop bit held low: framing error, break, then a clean frame.
    exp_q.push_back({1'b1, 8'hA3});
    send_frame(8'hA3, 3 * BIT_CLK);
    repeat (50) @(negedge clk);
    exp_q.push_back({1'b0, 8'h0F});
    send_frame(8'h0F, 0);
    wait_drain("drain_brk");
    check("brk_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);

    // Back-to-back frames with the consumer stalled: second frame overruns.
    bus.rx_ready = 1'b0;
    ovr_base = ovr_cnt;
    exp_q.push_back({1'b0, 8'h12});
    send_frame(8'h12, 0);
    send_frame(8'h34, 0);
    repeat (20) @(negedge clk);
    check("overrun_count", 32'(ovr_cnt - ovr_base), 32'd1);
    check("overrun_width", 32'(ovr_long), 32'd0);
    check("hold_valid", 32'(bus.rx_valid), 32'd1);
    check("hold_dout", 32'(bus.dout), 32'h12);
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    #2;
    check("valid_cleared", 32'(bus.rx_valid), 32'd0);
    check("sb_after_accept", 32'(exp_q.size()), 32'd0);

    // Consumer accepts in the very cycle the next frame completes.
    ovr_base = ovr_cnt;
    exp_q.push_back({1'b0, 8'h12});
    send_frame(8'h12, 0);
    exp_q.push_back({1'b0, 8'h34});
    fork
      send_frame(8'h34, 0);
      begin
        int s;
        @(negedge rx);
        s = cyc;
        for (int k = 0; k < 2000 && cyc != s + lat - 1; k++) @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("same_cycle_valid", 32'(bus.rx_valid), 32'd1);
    check("same_cycle_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    check("same_cycle_sb", 32'(exp_q.size()), 32'd1);
    bus.rx_ready = 1'b1;
    wait_drain("drain_34");

    // Reset in the middle of a frame clears every output at once.
    bus.rx_ready = 1'b0;
    send_frame(8'h5A, 0);
    repeat (10) @(negedge clk);
    check("pre_reset_dout", 32'(bus.dout), 32'h5A);
    fork
      send_frame(8'hC6, 0);
      begin
        @(negedge rx);
        repeat (300) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_dout", 32'(bus.dout), 32'd0);
        check("mid_rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
        check("mid_rst_overrun", 32'(bus.overrun), 32'd0);
      end
    join
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_valid", 32'(bus.rx_valid), 32'd0);
    bus.rx_ready = 1'b1;
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 0);
    wait_drain("drain_81");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
